// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: synchronises SCL/SDA, detects START/STOP,
// ACKs its own write address and every data byte, and NACKs reads.
module i2c_target_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [6:0] r_shift;
    logic       r_oe;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_start;
    logic       r_stop;
    logic       r_busy;

    state_t     w_state_nx;
    logic [2:0] w_cnt_nx;
    logic [6:0] w_shift_nx;
    logic       w_oe_nx;
    logic [7:0] w_data_nx;
    logic       w_valid_nx;
    logic       w_start_nx;
    logic       w_stop_nx;
    logic       w_busy_nx;

    logic       w_scl_s;
    logic       w_sda_s;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_last;
    logic [7:0] w_byte;
    logic       w_match;

    // Synchronisers and delay stage idle high so reset never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_d    <= r_scl_sync[1];
            r_sda_d    <= r_sda_sync[1];
        end
    end

    assign w_scl_s    = r_scl_sync[1];
    assign w_sda_s    = r_sda_sync[1];
    assign w_scl_rise = w_scl_s & ~r_scl_d;
    assign w_scl_fall = ~w_scl_s & r_scl_d;
    assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
    assign w_last     = (r_cnt == 3'd7);
    assign w_byte     = {r_shift, w_sda_s};
    assign w_match    = (w_byte[7:1] == DEV_ADDR) & ~w_byte[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_shift <= 7'd0;
            r_oe    <= 1'b0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_oe    <= w_oe_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_start <= w_start_nx;
            r_stop  <= w_stop_nx;
            r_busy  <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_oe_nx    = r_oe;
        w_data_nx  = r_data;
        w_valid_nx = 1'b0;
        w_start_nx = 1'b0;
        w_stop_nx  = 1'b0;
        w_busy_nx  = r_busy;
        // Bus conditions win over any SCL edge seen in the same cycle
        if (w_start) begin
            w_start_nx = 1'b1;
            w_busy_nx  = 1'b1;
            w_cnt_nx   = 3'd0;
            w_oe_nx    = 1'b0;
            w_state_nx = S_ADDR;
        end else if (w_stop) begin
            w_stop_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_cnt_nx   = 3'd0;
            w_oe_nx    = 1'b0;
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nx = w_byte[6:0];
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (w_last)
                            w_state_nx = w_match ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                S_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx = w_byte[6:0];
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (w_last) begin
                            w_data_nx  = w_byte;
                            w_valid_nx = 1'b1;
                            w_state_nx = S_DATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    // First fall ends bit 8 and grabs SDA; second ends the ACK clock
                    if (w_scl_fall) begin
                        if (!r_oe) begin
                            w_oe_nx = 1'b1;
                        end else begin
                            w_oe_nx    = 1'b0;
                            w_cnt_nx   = 3'd0;
                            w_state_nx = S_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = r_oe;
    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign start_det = r_start;
    assign stop_det  = r_stop;
    assign busy      = r_busy;

endmodule
